// File: rtl/decode_hazard_controller.sv
// ID-stage hazard sequencer: load-use stall, branch/jump flush, registered
// EX forwarding selects from an EX/MEM writer scoreboard, saturating counters.
//
// Ports:
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   id_valid                      instruction in ID is real (0 = bubble)
//   id_rs, id_rt                  source register fields of the ID instruction
//   id_uses_rs, id_uses_rt        ID instruction reads rs / rt
//   id_dest                       destination after the reg_dest mux
//   id_reg_write, id_mem_read     decoder reg_write / mem_read (load)
//   id_jump                       decoder jump
//   ex_branch_taken               branch in EX resolved taken
//   stall, flush_if_id            hold PC+IF/ID / zero IF/ID (combinational)
//   bubble_id_ex                  load NOP into ID/EX (combinational)
//   forward_a, forward_b          EX operand source: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   stall_count, flush_count      saturating event counters
module decode_hazard_controller #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       id_dest,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_jump,
    input  logic             ex_branch_taken,
    output logic             stall,
    output logic             flush_if_id,
    output logic             bubble_id_ex,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {RUN, STALL} state_t;

    state_t state, state_next;

    // Writers in flight. The WB slot is not kept: the regfile is
    // write-before-read, so a WB writer never needs forwarding.
    logic       ex_valid, ex_reg_write, ex_mem_read;
    logic [4:0] ex_dest;
    logic       mem_valid, mem_reg_write;
    logic [4:0] mem_dest;

    logic       hit_ex_rs, hit_ex_rt, hit_mem_rs, hit_mem_rt;
    logic       load_use;
    logic [1:0] fwd_a_next, fwd_b_next;

    assign hit_ex_rs  = ex_valid & ex_reg_write & (ex_dest == id_rs) & (id_rs != 5'd0);
    assign hit_ex_rt  = ex_valid & ex_reg_write & (ex_dest == id_rt) & (id_rt != 5'd0);
    assign hit_mem_rs = mem_valid & mem_reg_write & (mem_dest == id_rs) & (id_rs != 5'd0);
    assign hit_mem_rt = mem_valid & mem_reg_write & (mem_dest == id_rt) & (id_rt != 5'd0);

    assign load_use = id_valid & ex_mem_read &
                      ((id_uses_rs & hit_ex_rs) | (id_uses_rt & hit_ex_rt));

    always_comb begin
        state_next   = state;
        stall        = 1'b0;
        flush_if_id  = 1'b0;
        bubble_id_ex = 1'b0;
        unique case (state)
            RUN: begin
                if (load_use) begin
                    stall      = 1'b1;
                    state_next = STALL;
                end
            end
            STALL: state_next = RUN;
            default: state_next = RUN;
        endcase
        // A taken branch squashes whatever ID holds, so a pending stall is moot.
        if (ex_branch_taken) begin
            stall       = 1'b0;
            flush_if_id = 1'b1;
            state_next  = RUN;
        end else if (id_jump & id_valid) begin
            flush_if_id = 1'b1;
        end
        bubble_id_ex = stall | ex_branch_taken;
        if (reset) begin
            stall        = 1'b0;
            flush_if_id  = 1'b0;
            bubble_id_ex = 1'b0;
            state_next   = RUN;
        end
    end

    // Youngest writer (EX) takes priority over MEM.
    always_comb begin
        fwd_a_next = 2'b00;
        fwd_b_next = 2'b00;
        if (!bubble_id_ex) begin
            if (hit_ex_rs)       fwd_a_next = 2'b10;
            else if (hit_mem_rs) fwd_a_next = 2'b01;
            if (hit_ex_rt)       fwd_b_next = 2'b10;
            else if (hit_mem_rt) fwd_b_next = 2'b01;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= RUN;
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_dest       <= 5'd0;
            mem_valid     <= 1'b0;
            mem_reg_write <= 1'b0;
            mem_dest      <= 5'd0;
            forward_a     <= 2'b00;
            forward_b     <= 2'b00;
            stall_count   <= '0;
            flush_count   <= '0;
        end else begin
            state         <= state_next;
            mem_valid     <= ex_valid;
            mem_reg_write <= ex_reg_write;
            mem_dest      <= ex_dest;
            if (bubble_id_ex | ~id_valid) begin
                ex_valid     <= 1'b0;
                ex_reg_write <= 1'b0;
                ex_mem_read  <= 1'b0;
                ex_dest      <= 5'd0;
            end else begin
                ex_valid     <= 1'b1;
                ex_reg_write <= id_reg_write;
                ex_mem_read  <= id_mem_read;
                ex_dest      <= id_dest;
            end
            forward_a <= fwd_a_next;
            forward_b <= fwd_b_next;
            if (stall && stall_count != '1)
                stall_count <= stall_count + 1'b1;
            if (flush_if_id && flush_count != '1)
                flush_count <= flush_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_hazard_controller.sv
// Self-checking bench for decode_hazard_controller: directed pipeline
// scenarios plus randomized traffic against a writer-history reference model.
module tb_decode_hazard_controller;

    localparam int CNT_W = 6;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clock = 1'b0;
    logic reset;
    logic id_valid, id_uses_rs, id_uses_rt;
    logic [4:0] id_rs, id_rt, id_dest;
    logic id_reg_write, id_mem_read, id_jump, ex_branch_taken;
    logic stall, flush_if_id, bubble_id_ex;
    logic [1:0] forward_a, forward_b;
    logic [CNT_W-1:0] stall_count, flush_count;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    decode_hazard_controller #(.CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_dest(id_dest), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_jump(id_jump),
        .ex_branch_taken(ex_branch_taken),
        .stall(stall), .flush_if_id(flush_if_id), .bubble_id_ex(bubble_id_ex),
        .forward_a(forward_a), .forward_b(forward_b),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    // Reference model: history of instructions issued into EX ([0]=EX, [1]=MEM).
    typedef struct {
        bit       v;
        bit [4:0] d;
        bit       rw;
        bit       mr;
    } ent_t;

    ent_t pipe[$];
    bit [1:0] m_fa, m_fb;
    int m_sc, m_fc;
    bit e_stall, e_flush, e_bubble;

    function automatic bit writes(ent_t e, bit [4:0] r);
        return e.v && e.rw && e.d == r && r != 0;
    endfunction

    function automatic bit [1:0] src(bit [4:0] r);
        if (writes(pipe[0], r)) return 2'b10;
        if (writes(pipe[1], r)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_comb();
        bit lu;
        lu = id_valid && pipe[0].mr &&
             ((id_uses_rs && writes(pipe[0], id_rs)) ||
              (id_uses_rt && writes(pipe[0], id_rt)));
        e_stall  = lu && !ex_branch_taken;
        e_flush  = ex_branch_taken || (id_jump && id_valid);
        e_bubble = ex_branch_taken || e_stall;
        if (reset) begin
            e_stall = 0; e_flush = 0; e_bubble = 0;
        end
    endtask

    task automatic model_clear();
        ent_t z;
        z = '{v: 0, d: 0, rw: 0, mr: 0};
        pipe = {};
        pipe.push_back(z);
        pipe.push_back(z);
        m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0;
    endtask

    task automatic tick();
        ent_t ne;
        bit [1:0] na, nb;
        int nsc, nfc;
        bit rst;
        model_comb();
        rst = reset;
        ne = '{v: 0, d: 0, rw: 0, mr: 0};
        if (id_valid && !e_bubble)
            ne = '{v: 1, d: id_dest, rw: id_reg_write, mr: id_mem_read};
        na = e_bubble ? 2'b00 : src(id_rs);
        nb = e_bubble ? 2'b00 : src(id_rt);
        nsc = (e_stall && m_sc < CMAX) ? m_sc + 1 : m_sc;
        nfc = (e_flush && m_fc < CMAX) ? m_fc + 1 : m_fc;
        @(posedge clock);
        if (rst) begin
            model_clear();
        end else begin
            pipe.push_front(ne);
            void'(pipe.pop_back());
            m_fa = na; m_fb = nb; m_sc = nsc; m_fc = nfc;
        end
        #1;
    endtask

    task automatic settle();
        model_comb();
        @(negedge clock);
    endtask

    task automatic drive(bit v, bit [4:0] rs, bit [4:0] rt, bit urs, bit urt,
                         bit [4:0] d, bit rw, bit mr, bit j, bit br);
        id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        id_dest = d; id_reg_write = rw; id_mem_read = mr; id_jump = j;
        ex_branch_taken = br;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1;
        nop();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        drive(1, 1, 1, 1, 1, 1, 1, 1, 1, 1);
        tick();
        settle();
        checks++;
        if ({stall, flush_if_id, bubble_id_ex} !== 3'b000) begin
            errors++;
            $display("FAIL reset_comb got %b exp 000", {stall, flush_if_id, bubble_id_ex});
        end
        tick();
        reset = 0;
        nop();
        settle();
        checks++;
        if ({forward_a, forward_b} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_fwd got %b exp 0000", {forward_a, forward_b});
        end
        checks++;
        if (stall_count !== 0 || flush_count !== 0) begin
            errors++;
            $display("FAIL reset_cnt got %0d/%0d exp 0/0", stall_count, flush_count);
        end
    endtask

    task automatic test_alu_forward();
        do_reset();
        drive(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
        tick();
        drive(1, 3, 5, 1, 1, 4, 1, 0, 0, 0);
        settle();
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL alu_nostall got %b exp 0", stall);
        end
        tick();
        nop();
        settle();
        checks++;
        if (forward_a !== 2'b10 || forward_b !== 2'b00) begin
            errors++;
            $display("FAIL alu_fwd got %b/%b exp 10/00", forward_a, forward_b);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 1, 0, 1, 0, 2, 1, 1, 0, 0);
        tick();
        drive(1, 2, 2, 1, 1, 4, 1, 0, 0, 0);
        settle();
        checks++;
        if (stall !== 1'b1 || bubble_id_ex !== 1'b1 || flush_if_id !== 1'b0) begin
            errors++;
            $display("FAIL lu_stall got s%b b%b f%b exp s1 b1 f0",
                     stall, bubble_id_ex, flush_if_id);
        end
        tick();
        settle();
        checks++;
        if (stall !== 1'b0 || bubble_id_ex !== 1'b0) begin
            errors++;
            $display("FAIL lu_release got s%b b%b exp s0 b0", stall, bubble_id_ex);
        end
        tick();
        nop();
        settle();
        checks++;
        if (forward_a !== 2'b01 || forward_b !== 2'b01) begin
            errors++;
            $display("FAIL lu_fwd got %b/%b exp 01/01", forward_a, forward_b);
        end
        checks++;
        if (stall_count !== 1) begin
            errors++;
            $display("FAIL lu_count got %0d exp 1", stall_count);
        end
    endtask

    task automatic test_load_gap();
        do_reset();
        drive(1, 1, 0, 1, 0, 2, 1, 1, 0, 0);
        tick();
        nop();
        tick();
        drive(1, 2, 0, 1, 1, 4, 1, 0, 0, 0);
        settle();
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL gap_nostall got %b exp 0", stall);
        end
        tick();
        nop();
        settle();
        checks++;
        if (forward_a !== 2'b01 || forward_b !== 2'b00) begin
            errors++;
            $display("FAIL gap_fwd got %b/%b exp 01/00", forward_a, forward_b);
        end
    endtask

    task automatic test_zero_reg();
        do_reset();
        drive(1, 1, 2, 1, 1, 0, 1, 0, 0, 0);
        tick();
        drive(1, 1, 0, 1, 0, 0, 1, 1, 0, 0);
        tick();
        drive(1, 0, 0, 1, 1, 5, 1, 0, 0, 0);
        settle();
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL zero_stall got %b exp 0", stall);
        end
        tick();
        nop();
        settle();
        checks++;
        if (forward_a !== 2'b00 || forward_b !== 2'b00) begin
            errors++;
            $display("FAIL zero_fwd got %b/%b exp 00/00", forward_a, forward_b);
        end
    endtask

    task automatic test_branch_over_stall();
        do_reset();
        drive(1, 1, 0, 1, 0, 2, 1, 1, 0, 0);
        tick();
        drive(1, 2, 2, 1, 1, 4, 1, 0, 0, 1);
        settle();
        checks++;
        if (stall !== 1'b0 || flush_if_id !== 1'b1 || bubble_id_ex !== 1'b1) begin
            errors++;
            $display("FAIL br_ctrl got s%b f%b b%b exp s0 f1 b1",
                     stall, flush_if_id, bubble_id_ex);
        end
        tick();
        drive(1, 3, 3, 1, 1, 6, 1, 0, 0, 0);
        settle();
        checks++;
        if (flush_count !== 1 || stall !== 1'b0 || forward_a !== 2'b00) begin
            errors++;
            $display("FAIL br_after got fc%0d s%b fa%b exp fc1 s0 fa00",
                     flush_count, stall, forward_a);
        end
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        settle();
        checks++;
        if (flush_if_id !== 1'b1 || bubble_id_ex !== 1'b0) begin
            errors++;
            $display("FAIL jump got f%b b%b exp f1 b0", flush_if_id, bubble_id_ex);
        end
    endtask

    task automatic test_saturate_and_reset();
        do_reset();
        for (int i = 0; i < CMAX + 6; i++) begin
            drive(1, 1, 0, 1, 0, 2, 1, 1, 0, 0);
            tick();
            drive(1, 2, 2, 1, 1, 4, 1, 0, 0, 0);
            tick();
            tick();
        end
        nop();
        settle();
        checks++;
        if (stall_count !== CNT_W'(CMAX) || m_sc != CMAX) begin
            errors++;
            $display("FAIL sat_hold got %0d exp %0d", stall_count, CMAX);
        end
        drive(1, 1, 0, 1, 0, 2, 1, 1, 0, 0);
        tick();
        drive(1, 2, 2, 1, 1, 4, 1, 0, 0, 0);
        settle();
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL sat_stall got %b exp 1", stall);
        end
        tick();
        reset = 1;
        tick();
        reset = 0;
        settle();
        checks++;
        if (stall !== 1'b0 || forward_a !== 2'b00 || forward_b !== 2'b00) begin
            errors++;
            $display("FAIL rst_stall got s%b fa%b fb%b exp s0 fa00 fb00",
                     stall, forward_a, forward_b);
        end
        checks++;
        if (stall_count !== 0 || flush_count !== 0) begin
            errors++;
            $display("FAIL rst_cnt got %0d/%0d exp 0/0", stall_count, flush_count);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 79) == 0);
            drive($urandom_range(0, 5) != 0,
                  5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
                  1'($urandom), 1'($urandom), 5'($urandom_range(0, 5)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0);
            settle();
            checks++;
            if ({stall, flush_if_id, bubble_id_ex} !== {e_stall, e_flush, e_bubble}) begin
                errors++;
                $display("FAIL rnd_ctrl cyc %0d got %b exp %b", i,
                         {stall, flush_if_id, bubble_id_ex}, {e_stall, e_flush, e_bubble});
            end
            checks++;
            if (forward_a !== m_fa || forward_b !== m_fb) begin
                errors++;
                $display("FAIL rnd_fwd cyc %0d got %b/%b exp %b/%b", i,
                         forward_a, forward_b, m_fa, m_fb);
            end
            checks++;
            if (stall_count !== CNT_W'(m_sc) || flush_count !== CNT_W'(m_fc)) begin
                errors++;
                $display("FAIL rnd_cnt cyc %0d got %0d/%0d exp %0d/%0d", i,
                         stall_count, flush_count, m_sc, m_fc);
            end
            tick();
        end
        reset = 0;
    endtask

    initial begin
        model_clear();
        reset = 1;
        nop();
        test_reset();
        test_alu_forward();
        test_load_use();
        test_load_gap();
        test_zero_reg();
        test_branch_over_stall();
        test_saturate_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
